// File: rtl/sensor_debounce_bank_pkg.sv
// Shared constants and types for the sensor debounce bank.
// Default timing windows are derived from the 50 MHz system clock.
package sensor_debounce_bank_pkg;

  localparam int unsigned SYS_CLK_HZ              = 32'd50_000_000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = SYS_CLK_HZ / 32'd1000;
  localparam int unsigned DEFAULT_STUCK_CYCLES    = SYS_CLK_HZ * 32'd10;

  localparam int unsigned CH_BOWL    = 32'd0;
  localparam int unsigned CH_STORAGE = 32'd1;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic sticky;
    logic stuck;
  } ch_out_t;

endpackage

// File: rtl/sensor_debounce_bank_channel.sv
// One conditioned sensor channel: synchroniser, polarity, debounce, edges, sticky.
// Optional stuck-active detector is built only when SENSOR_STUCK_DET_EN is defined.
module debounce_channel
  import sensor_debounce_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic        ACTIVE_LOW      = 1'b1,
  parameter int unsigned STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    raw_i,
  input  logic    clr_i,
  output ch_out_t out_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             sample;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             sticky_q, sticky_d;
  logic             stuck;

  // Debounce next-state: count cycles of disagreement, restart on any agreement.
  always_comb begin
    sample   = sync2_q ^ ACTIVE_LOW;
    cnt_inc  = cnt_q + CNT_W'(1);
    cnt_d    = {CNT_W{1'b0}};
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sample != level_q) begin
      if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
        fall_d  = level_q;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_inc;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    // A rise being presented beats a clear arriving in the same cycle.
    sticky_d = rise_q | (sticky_q & ~clr_i);
  end

  // Channel state registers; sync stages reset to the inactive pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= ACTIVE_LOW;
      sync2_q  <= ACTIVE_LOW;
      cnt_q    <= {CNT_W{1'b0}};
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef SENSOR_STUCK_DET_EN
  localparam int unsigned STK_W = $clog2(STUCK_CYCLES + 1);

  logic [STK_W-1:0] stk_cnt_q, stk_cnt_d;
  logic             stuck_q, stuck_d;

  // Saturating active-time counter; stuck drops on the same edge the level falls.
  always_comb begin
    stk_cnt_d = {STK_W{1'b0}};
    if (level_q) begin
      if (stk_cnt_q == STK_W'(STUCK_CYCLES)) begin
        stk_cnt_d = stk_cnt_q;
      end else begin
        stk_cnt_d = stk_cnt_q + STK_W'(1);
      end
    end else begin
      stk_cnt_d = {STK_W{1'b0}};
    end
    stuck_d = level_d & (stuck_q | (level_q & (stk_cnt_d == STK_W'(STUCK_CYCLES))));
  end

  // Stuck detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stk_cnt_q <= {STK_W{1'b0}};
      stuck_q   <= 1'b0;
    end else begin
      stk_cnt_q <= stk_cnt_d;
      stuck_q   <= stuck_d;
    end
  end

  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  assign out_o = '{level: level_q, rise: rise_q, fall: fall_q, sticky: sticky_q, stuck: stuck};

endmodule

// File: rtl/sensor_debounce_bank.sv
// N-channel presence-sensor conditioner; stuck detection needs SENSOR_STUCK_DET_EN.
// Channels are independent; the bank only adds the any-active summary.
module sensor_debounce_bank
  import sensor_debounce_bank_pkg::*;
#(
  parameter int unsigned       N_CH            = 32'd2,
  parameter int unsigned       DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic [N_CH-1:0]   ACTIVE_LOW      = {N_CH{1'b1}},
  parameter int unsigned       STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] raw_i,
  input  logic [N_CH-1:0] clr_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] sticky_o,
  output logic            any_active_o,
  output logic [N_CH-1:0] stuck_o
);

  ch_out_t ch_out [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW[i]),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .raw_i (raw_i[i]),
      .clr_i (clr_i[i]),
      .out_o (ch_out[i])
    );

    assign level_o[i]  = ch_out[i].level;
    assign rise_o[i]   = ch_out[i].rise;
    assign fall_o[i]   = ch_out[i].fall;
    assign sticky_o[i] = ch_out[i].sticky;
    assign stuck_o[i]  = ch_out[i].stuck;
  end

  assign any_active_o = |level_o;

endmodule

// File: tb/tb_sensor_debounce_bank.sv
// Scoreboard bench for sensor_debounce_bank: a window-based reference model
// pushes expected outputs per clock, a negedge monitor pops and compares.
module tb_sensor_debounce_bank;
  localparam int D     = 4;
  localparam int STUCK = 20;
  localparam logic [1:0] AL = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] raw_i, clr_i;
  logic [1:0] level_o, rise_o, fall_o, sticky_o, stuck_o;
  logic       any_active_o;

  sensor_debounce_bank #(
    .N_CH(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(AL), .STUCK_CYCLES(STUCK)
  ) dut (
    .clk(clk), .rst(rst), .raw_i(raw_i), .clr_i(clr_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .sticky_o(sticky_o), .any_active_o(any_active_o), .stuck_o(stuck_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] level, rise, fall, sticky, stuck;
    logic       any;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] hist[$];   // normalised raw sample taken at each edge
  int         k = 0;
  int         last_rst = -1;
  int         rise_k[2];
  logic [1:0] m_level = 2'b00, m_rise = 2'b00, m_fall = 2'b00, m_sticky = 2'b00, m_stuck = 2'b00;
  int         n_cmp = 0, n_err = 0;

  function automatic logic samp(input int idx, input int ch);
    if (idx < 0 || idx <= last_rst) return 1'b0;
    return hist[idx][ch];
  endfunction

  // Level flips when the last D synchronised samples all disagree with it.
  task automatic model_edge(input logic r, input logic [1:0] raw, input logic [1:0] clr);
    exp_t e;
    hist.push_back(r ? 2'b00 : (raw ^ AL));
    if (r) begin
      m_level = 2'b00; m_rise = 2'b00; m_fall = 2'b00; m_sticky = 2'b00;
      last_rst = k;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        bit all_diff = 1'b1;
        for (int m = 0; m < D; m++)
          if (samp(k - 2 - m, ch) == m_level[ch]) all_diff = 1'b0;
        m_sticky[ch] = m_rise[ch] | (m_sticky[ch] & ~clr[ch]);
        m_rise[ch] = 1'b0;
        m_fall[ch] = 1'b0;
        if (all_diff) begin
          m_level[ch] = ~m_level[ch];
          m_rise[ch]  = m_level[ch];
          m_fall[ch]  = ~m_level[ch];
          if (m_level[ch]) rise_k[ch] = k;
        end
      end
    end
    for (int ch = 0; ch < 2; ch++) begin
`ifdef SENSOR_STUCK_DET_EN
      m_stuck[ch] = m_level[ch] && ((k - rise_k[ch]) >= STUCK);
`else
      m_stuck[ch] = 1'b0;
`endif
    end
    e.level = m_level; e.rise = m_rise; e.fall = m_fall;
    e.sticky = m_sticky; e.stuck = m_stuck; e.any = |m_level;
    sb_q.push_back(e);
    k++;
  endtask

  task automatic step(input logic r, input logic [1:0] raw, input logic [1:0] clr);
    @(negedge clk);
    rst = r; raw_i = raw; clr_i = clr;
    @(posedge clk);
    #1;
    model_edge(r, raw, clr);
  endtask

  task automatic hold(input int n, input logic [1:0] raw);
    for (int i = 0; i < n; i++) step(1'b0, raw, 2'b00);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, k, act, exp);
    end
  endtask

  // Monitor: compare whatever the model expects for the most recent edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("level",  level_o,  e.level);
      check("rise",   rise_o,   e.rise);
      check("fall",   fall_o,   e.fall);
      check("sticky", sticky_o, e.sticky);
      check("stuck",  stuck_o,  e.stuck);
      check("any",    {1'b0, any_active_o}, {1'b0, e.any});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; raw_i = 2'b11; clr_i = 2'b00;
    rise_k[0] = 0; rise_k[1] = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 2'b00);
    hold(3, 2'b11);
    hold(12, 2'b10);                 // ch0 active
    hold(3, 2'b00);                  // ch1 glitch shorter than window
    hold(8, 2'b10);
    hold(8, 2'b11);                  // ch0 released
    hold(10, 2'b00);                 // both active together
    hold(10, 2'b11);                 // both released together
    // Clear coinciding with a new rise, then a clear on its own
    begin
      int t = 0;
      while (t < 20 && !m_rise[0]) begin
        step(1'b0, 2'b10, 2'b00);
        t++;
      end
      n_cmp++;
      if (!m_rise[0]) begin
        n_err++;
        $display("FAIL rise_wait: got no rise within 20 cycles expected rise on ch0");
      end
    end
    step(1'b0, 2'b10, 2'b01);
    hold(3, 2'b10);
    step(1'b0, 2'b10, 2'b01);
    hold(30, 2'b10);                 // long active period for stuck detection
    hold(10, 2'b11);
    // Reset in the middle of a count, then input active at reset release
    hold(3, 2'b00);
    step(1'b1, 2'b00, 2'b00);
    hold(12, 2'b00);
    hold(10, 2'b11);
    // Randomised segments: glitches, accepted changes, clears, occasional reset
    for (int s = 0; s < 250; s++) begin
      logic [1:0] raw;
      int len;
      raw = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 39) == 0) step(1'b1, raw, 2'b00);
      for (int i = 0; i < len; i++)
        step(1'b0, raw, ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end
    begin
      int w = 0;
      while (sb_q.size() > 0 && w < 10) begin
        @(negedge clk);
        w++;
      end
      #1;
      n_cmp++;
      if (sb_q.size() != 0) begin
        n_err++;
        $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
